routermerge_arbiter: RTL and testbench
======================================

Name: routermerge_arbiter

Overview:
- Synchronous round-robin packet arbiter that generates the select-token stream consumed by the 5-input router merge. It issues one 3-bit select token per flit transferred.
- Watches the head-of-queue flit type at each of the 5 merge inputs and grants one input per packet, holding the grant from head flit to tail flit.
- Sits beside the merge and drives its control_in channel. It pops upstream input queues in lock-step with token acceptance.

Parameters:
- NUM_IN, 5, number of merge inputs (1..8).
- SEL_W, 3, select token width; must satisfy 2**SEL_W >= NUM_IN.
- TIMEOUT, 64, watchdog cycle limit (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_IN  input i has a flit at its queue head.
- req_type  in  2*NUM_IN  head-flit type of input i, at bits [2i+1:2i]: 00 body, 01 head, 10 tail, 11 single (head and tail).
- ctrl_valid  out  1  select token valid.
- ctrl_ready  in  1  merge accepts the token.
- ctrl_sel  out  SEL_W  index of the input to forward.
- pop  out  NUM_IN  one-hot; pop[i] = ctrl_valid & ctrl_ready & (ctrl_sel==i). Combinational from registered state and ctrl_ready.
- busy  out  1  a packet lock is held.
- lock_id  out  SEL_W  currently locked input; 0 when not locked.
- err_timeout  out  1  sticky watchdog error (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (asynchronous):
  - ctrl_valid=0, ctrl_sel=0, busy=0, lock_id=0, err_timeout=0.
  - Round-robin pointer rr_ptr=0; state IDLE.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Scan inputs starting at rr_ptr, wrapping modulo NUM_IN. Select the first i with req_valid[i]=1 and type head(01) or single(11).
  - If found: go to ISSUE next cycle with ctrl_valid=1 and ctrl_sel=i. Set busy=1 and lock_id=i, except for a single flit, which does not lock.
  - Latency from a valid head to ctrl_valid is 1 cycle.
  - Inputs presenting body or tail while unlocked are a protocol error; they are ignored and never granted.
- ISSUE:
  - ctrl_valid and ctrl_sel stay stable until ctrl_ready=1.
  - On the handshake cycle, pop fires. Then:
    - If the flit was tail or single: clear busy, set rr_ptr=(granted+1) mod NUM_IN, go to IDLE.
    - Otherwise: go to WAIT with ctrl_valid=0.
- WAIT:
  - The upstream queue updates during this cycle. Sample the locked input on the next edge.
  - If req_valid[lock_id] and type is body or tail: issue a token (ISSUE).
  - If the locked input is not valid: stay in WAIT, and do not grant any other input (packet integrity).
  - A head or single arriving on the locked input mid-packet is a protocol error; it is treated as body.
- Throughput: at most one token per 2 cycles while locked; a new packet may start the cycle after a tail is accepted.
- Simultaneous heads are resolved by the round-robin order from rr_ptr. The pointer advances only on packet completion.
- ctrl_ready asserted while ctrl_valid=0 has no effect.
- RESET mid-packet drops the lock immediately. Upstream is responsible for flushing partial packets.

Optional Feature:
- Macro: ROUTERMERGE_ARB_WATCHDOG_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT+1) increments each cycle in WAIT or ISSUE without a handshake, and clears on handshake.
  - When the counter reaches TIMEOUT: set err_timeout (sticky until RESET), drop the lock, deassert ctrl_valid, advance rr_ptr past lock_id, and go to IDLE.
- When undefined: no counter exists, err_timeout=0, and the lock may be held indefinitely.

Decomposition:
- Package routermerge_pkg:
  - flit_type_t enum (FLIT_BODY=2'b00, FLIT_HEAD=2'b01, FLIT_TAIL=2'b10, FLIT_SINGLE=2'b11).
  - arb_state_t enum (IDLE, ISSUE, WAIT).
  - Constants FLIT_W=11 and NUM_MERGE_IN=5.
- Sub-module rr_priority_pick: combinational rotate-and-priority-encode. Inputs are the request mask and rr_ptr; outputs are found and index. Reused by later multi-port arbiters.

Test Plan:
- Single packet: after reset, input 2 presents head, body, tail, and ctrl_ready is held 1 -> sel=2 three times, 2-cycle spacing; pop[2] pulses 3 times; busy is high from the first token to the tail; rr_ptr ends at 3.
- Contention: inputs 0 and 3 both present single flits simultaneously with rr_ptr=0 -> sel=0 then sel=3; rr_ptr ends at 4.
- Lock hold: input 1 is mid-packet with req_valid[1]=0 for 10 cycles while input 4 offers a head -> no token is issued and input 4 is not granted; after input 1's tail, the next token is sel=4.
- Backpressure: ctrl_ready=0 for 5 cycles during ISSUE -> ctrl_valid and ctrl_sel stay stable and pop stays 0; a single pop occurs on the cycle ctrl_ready rises.
- Wrap and fairness: all 5 inputs stream single flits continuously -> sel sequence is 0,1,2,3,4,0,...; no input is skipped over 20 tokens.
- Reset and watchdog:
  - Assert RESET mid-packet -> all outputs are 0 asynchronously.
  - With the watchdog macro defined and TIMEOUT=8: stall the locked input -> err_timeout=1 on the 8th idle cycle, busy=0, and the next grant goes to a different input.

Source files
------------

// File: rtl/routermerge_pkg.sv
// Shared types and constants for the router merge and its select-token arbiter.
package routermerge_pkg;

  localparam int FLIT_W       = 11;
  localparam int NUM_MERGE_IN = 5;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping modulo NUM_IN.
module rr_priority_pick #(
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  int cand;

  // ptr is always kept below NUM_IN by its owner, so one subtraction suffices to wrap
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/routermerge_arbiter.sv
// Round-robin packet arbiter producing the select-token stream for the 5-input router merge.
// Define ROUTERMERGE_ARB_WATCHDOG_EN to add the stalled-lock watchdog and sticky err_timeout.
module routermerge_arbiter
  import routermerge_pkg::*;
#(
  parameter int NUM_IN  = NUM_MERGE_IN,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_IN-1:0]   req_valid,
  input  logic [2*NUM_IN-1:0] req_type,
  output logic                ctrl_valid,
  input  logic                ctrl_ready,
  output logic [SEL_W-1:0]    ctrl_sel,
  output logic [NUM_IN-1:0]   pop,
  output logic                busy,
  output logic [SEL_W-1:0]    lock_id,
  output logic                err_timeout
);

  if ((1 << SEL_W) < NUM_IN || NUM_IN < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("routermerge_arbiter: invalid NUM_IN/SEL_W/TIMEOUT combination");
  end

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] rr_q, rr_d, sel_q, sel_d, lock_q, lock_d;
  logic             busy_q, busy_d, last_q, last_d;
  logic [NUM_IN-1:0] head_mask;
  logic             pick_found, handshake, wd_expire;
  logic [SEL_W-1:0] pick_idx;
  flit_type_t       pick_type, lock_type;

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  // Only head or single flits may open a packet; bit 0 of the type marks both
  always_comb begin
    head_mask = '0;
    for (int i = 0; i < NUM_IN; i++) head_mask[i] = req_valid[i] & req_type[2*i];
  end

  rr_priority_pick #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_pick (
    .req   (head_mask),
    .ptr   (rr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_type  = flit_type_t'(req_type[2*pick_idx +: 2]);
  assign lock_type  = flit_type_t'(req_type[2*lock_q +: 2]);
  assign ctrl_valid = (state_q == ISSUE);
  assign ctrl_sel   = sel_q;
  assign busy       = busy_q;
  assign lock_id    = lock_q;
  assign handshake  = ctrl_valid & ctrl_ready;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_IN; i++) pop[i] = handshake && (sel_q == SEL_W'(i));
  end

`ifdef ROUTERMERGE_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Counts cycles a token or a locked packet goes without progress
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == IDLE || handshake || wd_expire) wd_cnt <= '0;
      else wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire) err_q <= 1'b1;
    end
  end

  assign wd_expire   = (state_q != IDLE) && !handshake && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err_timeout = err_q;
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // last_q marks that the token on offer closes its packet (tail or single)
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    lock_d  = lock_q;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ISSUE;
          sel_d   = pick_idx;
          if (pick_type == FLIT_SINGLE) begin
            last_d = 1'b1;
            busy_d = 1'b0;
            lock_d = '0;
          end else begin
            last_d = 1'b0;
            busy_d = 1'b1;
            lock_d = pick_idx;
          end
        end
      end
      ISSUE: begin
        if (ctrl_ready) begin
          if (last_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            lock_d  = '0;
            rr_d    = next_idx(sel_q);
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A stray head/single on the locked input is carried as body
        if (req_valid[lock_q]) begin
          state_d = ISSUE;
          last_d  = (lock_type == FLIT_TAIL);
        end
      end
      default: state_d = IDLE;
    endcase
    if (wd_expire) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      lock_d  = '0;
      rr_d    = next_idx(sel_q);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      lock_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_routermerge_arbiter.sv
// Directed self-checking bench for routermerge_arbiter (NUM_IN=5, SEL_W=3, TIMEOUT=8).
module tb_routermerge_arbiter;
  import routermerge_pkg::*;

`ifdef ROUTERMERGE_ARB_WATCHDOG_EN
  localparam int STALL = 5;
`else
  localparam int STALL = 10;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [4:0] req_valid = '0;
  logic [9:0] req_type = '0;
  logic       ctrl_ready = 1'b0;
  logic       ctrl_valid, busy, err_timeout;
  logic [2:0] ctrl_sel, lock_id;
  logic [4:0] pop;

  int checks = 0;
  int failures = 0;

  routermerge_arbiter #(.NUM_IN(5), .SEL_W(3), .TIMEOUT(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .req_valid   (req_valid),
    .req_type    (req_type),
    .ctrl_valid  (ctrl_valid),
    .ctrl_ready  (ctrl_ready),
    .ctrl_sel    (ctrl_sel),
    .pop         (pop),
    .busy        (busy),
    .lock_id     (lock_id),
    .err_timeout (err_timeout)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] types(input logic [1:0] t0, t1, t2, t3, t4);
    return {t4, t3, t2, t1, t0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] v, input logic [9:0] t, input logic rdy);
    req_valid  = v;
    req_type   = t;
    ctrl_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(5'b00000, '0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", ctrl_valid, 0);
    checkOutput("rst_sel", ctrl_sel, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_lock", lock_id, 0);
    checkOutput("rst_err", err_timeout, 0);
    checkOutput("rst_pop", pop, 0);
    RESET = 1'b0;

    // Single 3-flit packet on input 2 with ready held high
    applyStimulus(5'b00100, types(FLIT_BODY, FLIT_BODY, FLIT_HEAD, FLIT_BODY, FLIT_BODY), 1'b1);
    tick();
    checkOutput("pkt_head_valid", ctrl_valid, 1);
    checkOutput("pkt_head_sel", ctrl_sel, 2);
    checkOutput("pkt_head_busy", busy, 1);
    checkOutput("pkt_head_lock", lock_id, 2);
    checkOutput("pkt_head_pop", pop, 5'b00100);
    tick();
    checkOutput("pkt_wait1_valid", ctrl_valid, 0);
    checkOutput("pkt_wait1_pop", pop, 0);
    checkOutput("pkt_wait1_busy", busy, 1);
    applyStimulus(5'b00100, types(FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_BODY), 1'b1);
    tick();
    checkOutput("pkt_body_valid", ctrl_valid, 1);
    checkOutput("pkt_body_sel", ctrl_sel, 2);
    checkOutput("pkt_body_pop", pop, 5'b00100);
    tick();
    checkOutput("pkt_wait2_valid", ctrl_valid, 0);
    applyStimulus(5'b00100, types(FLIT_BODY, FLIT_BODY, FLIT_TAIL, FLIT_BODY, FLIT_BODY), 1'b1);
    tick();
    checkOutput("pkt_tail_valid", ctrl_valid, 1);
    checkOutput("pkt_tail_sel", ctrl_sel, 2);
    checkOutput("pkt_tail_pop", pop, 5'b00100);
    checkOutput("pkt_tail_busy", busy, 1);
    tick();
    applyStimulus(5'b00000, '0, 1'b1);
    checkOutput("pkt_done_busy", busy, 0);
    checkOutput("pkt_done_lock", lock_id, 0);
    checkOutput("pkt_done_valid", ctrl_valid, 0);

    // Pointer now 3: singles on 1 and 3 must grant 3 first, then 1
    applyStimulus(5'b01010, types(FLIT_BODY, FLIT_SINGLE, FLIT_BODY, FLIT_SINGLE, FLIT_BODY), 1'b1);
    tick();
    checkOutput("rr3_first_sel", ctrl_sel, 3);
    checkOutput("rr3_single_busy", busy, 0);
    checkOutput("rr3_single_lock", lock_id, 0);
    tick();
    applyStimulus(5'b00010, types(FLIT_BODY, FLIT_SINGLE, FLIT_BODY, FLIT_BODY, FLIT_BODY), 1'b1);
    checkOutput("rr3_gap_valid", ctrl_valid, 0);
    tick();
    checkOutput("rr3_second_sel", ctrl_sel, 1);
    tick();
    applyStimulus(5'b00000, '0, 1'b1);

    // Asynchronous reset while a packet on input 1 is being offered
    applyStimulus(5'b00010, types(FLIT_BODY, FLIT_HEAD, FLIT_BODY, FLIT_BODY, FLIT_BODY), 1'b0);
    tick();
    checkOutput("arst_pre_sel", ctrl_sel, 1);
    checkOutput("arst_pre_busy", busy, 1);
    ctrl_ready = 1'b1;
    #2 RESET = 1'b1;
    #1;
    checkOutput("arst_valid", ctrl_valid, 0);
    checkOutput("arst_sel", ctrl_sel, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_lock", lock_id, 0);
    checkOutput("arst_pop", pop, 0);
    applyStimulus(5'b00000, '0, 1'b0);
    tick();
    RESET = 1'b0;

    // Contention from pointer 0: singles on 0 and 3
    applyStimulus(5'b01001, types(FLIT_SINGLE, FLIT_BODY, FLIT_BODY, FLIT_SINGLE, FLIT_BODY), 1'b1);
    tick();
    checkOutput("cont_first_sel", ctrl_sel, 0);
    tick();
    applyStimulus(5'b01000, types(FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_SINGLE, FLIT_BODY), 1'b1);
    tick();
    checkOutput("cont_second_sel", ctrl_sel, 3);
    tick();
    applyStimulus(5'b00000, '0, 1'b1);

    // Backpressure with pointer 4: singles on 4 and 0, ready low for 5 cycles
    applyStimulus(5'b10001, types(FLIT_SINGLE, FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_SINGLE), 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold_valid", ctrl_valid, 1);
      checkOutput("bp_hold_sel", ctrl_sel, 4);
      checkOutput("bp_hold_pop", pop, 0);
      if (k < 4) tick();
    end
    ctrl_ready = 1'b1;
    #1;
    checkOutput("bp_release_pop", pop, 5'b10000);
    tick();
    applyStimulus(5'b00001, types(FLIT_SINGLE, FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_BODY), 1'b1);
    checkOutput("bp_after_valid", ctrl_valid, 0);
    tick();
    checkOutput("bp_next_sel", ctrl_sel, 0);
    tick();
    applyStimulus(5'b00000, '0, 1'b1);

    // Lock hold: input 1 locked and stalled while input 4 offers a head
    applyStimulus(5'b10010, types(FLIT_BODY, FLIT_HEAD, FLIT_BODY, FLIT_BODY, FLIT_HEAD), 1'b1);
    tick();
    checkOutput("lock_sel", ctrl_sel, 1);
    checkOutput("lock_id", lock_id, 1);
    tick();
    applyStimulus(5'b10000, types(FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_HEAD), 1'b1);
    for (int k = 0; k < STALL; k++) begin
      tick();
      checkOutput("lock_stall_valid", ctrl_valid, 0);
      checkOutput("lock_stall_pop", pop, 0);
    end
    checkOutput("lock_stall_busy", busy, 1);
    checkOutput("lock_stall_id", lock_id, 1);
    checkOutput("lock_stall_err", err_timeout, 0);
    applyStimulus(5'b10010, types(FLIT_BODY, FLIT_TAIL, FLIT_BODY, FLIT_BODY, FLIT_HEAD), 1'b1);
    tick();
    checkOutput("lock_tail_sel", ctrl_sel, 1);
    checkOutput("lock_tail_valid", ctrl_valid, 1);
    tick();
    applyStimulus(5'b10000, types(FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_HEAD), 1'b1);
    tick();
    checkOutput("lock_next_sel", ctrl_sel, 4);
    checkOutput("lock_next_id", lock_id, 4);
    tick();
    applyStimulus(5'b10000, types(FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_BODY, FLIT_TAIL), 1'b1);
    tick();
    checkOutput("lock4_tail_sel", ctrl_sel, 4);
    tick();
    applyStimulus(5'b00000, '0, 1'b1);

    // Wrap and fairness: all inputs stream singles, pointer starts at 0
    applyStimulus(5'b11111, types(FLIT_SINGLE, FLIT_SINGLE, FLIT_SINGLE, FLIT_SINGLE, FLIT_SINGLE), 1'b1);
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput("fair_valid", ctrl_valid, 1);
      checkOutput("fair_sel", ctrl_sel, k % 5);
      tick();
    end
    applyStimulus(5'b00000, '0, 1'b1);

    // Body/tail while unlocked is never granted
    applyStimulus(5'b00110, types(FLIT_BODY, FLIT_BODY, FLIT_TAIL, FLIT_BODY, FLIT_BODY), 1'b1);
    tick();
    checkOutput("proto_valid1", ctrl_valid, 0);
    checkOutput("proto_pop", pop, 0);
    tick();
    checkOutput("proto_valid2", ctrl_valid, 0);
    checkOutput("proto_busy", busy, 0);
    applyStimulus(5'b00000, '0, 1'b1);

`ifdef ROUTERMERGE_ARB_WATCHDOG_EN
    // Watchdog: input 0 locked then stalled; input 2 waits with a head
    applyStimulus(5'b00101, types(FLIT_HEAD, FLIT_BODY, FLIT_HEAD, FLIT_BODY, FLIT_BODY), 1'b1);
    tick();
    checkOutput("wd_lock_sel", ctrl_sel, 0);
    tick();
    applyStimulus(5'b00100, types(FLIT_BODY, FLIT_BODY, FLIT_HEAD, FLIT_BODY, FLIT_BODY), 1'b1);
    for (int k = 0; k < 7; k++) begin
      tick();
      checkOutput("wd_pre_err", err_timeout, 0);
    end
    tick();
    checkOutput("wd_err", err_timeout, 1);
    checkOutput("wd_busy", busy, 0);
    checkOutput("wd_valid", ctrl_valid, 0);
    tick();
    checkOutput("wd_next_sel", ctrl_sel, 2);
    checkOutput("wd_next_valid", ctrl_valid, 1);
    checkOutput("wd_err_sticky", err_timeout, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
